// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch FSM (one outstanding request) feeding a DEPTH-entry queue.
// Defining FETCH_QUEUE_PERF_EN adds a saturating counter of cycles spent starved (empty_cycles_o).
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    output logic                       valid_o,
    output logic [31:0]                inst_o,
    output logic [31:0]                pc_o,
    input  logic                       deq_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [31:0]                empty_cycles_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];
    logic            wr_en;
    logic            rd_en;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;

        // A redirect flushes everything and wins over any ack or dequeue in the same cycle.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            wr_en = (state_q == REQ) && imem_ack_i;
            rd_en = deq_i && (count_q != '0);
            if (wr_en) begin
                tail_d     = tail_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rd_en) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end

        unique case (state_q)
            IDLE: begin
                if (start_i && !redirect_i && (count_q < FULL)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack_i) begin
                    state_d = (!redirect_i && start_i && (count_d < FULL)) ? REQ : IDLE;
                end else if (redirect_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            // NOTE: the storage is reset on purpose so inst_o/pc_o read as zero before the first write.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (wr_en) begin
                mem_q[tail_q] <= '{pc: fetch_pc_q, inst: imem_data_i};
            end
        end
    end

    assign imem_req_o  = (state_q != IDLE);
    assign imem_addr_o = fetch_pc_q;
    assign valid_o     = (count_q != '0);
    assign inst_o      = mem_q[head_q].inst;
    assign pc_o        = mem_q[head_q].pc;
    assign count_o     = count_q;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] empty_cycles_q, empty_cycles_d;

    always_comb begin
        empty_cycles_d = empty_cycles_q;
        if (start_i && !valid_o && (empty_cycles_q != '1)) begin
            empty_cycles_d = empty_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            empty_cycles_q <= '0;
        end else begin
            empty_cycles_q <= empty_cycles_d;
        end
    end

    assign empty_cycles_o = empty_cycles_q;
`else
    assign empty_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a memory responder plus a scoreboard of expected queue entries.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef FETCH_QUEUE_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd5;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_ack_i;
    logic [31:0]   imem_data_i;
    logic          valid_o;
    logic [31:0]   inst_o;
    logic [31:0]   pc_o;
    logic          deq_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic [CW-1:0] count_o;
    logic [31:0]   empty_cycles_o;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    bit          auto_mem;
    int          ack_delay;
    int          wait_cnt;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .valid_o       (valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .deq_i         (deq_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .count_o       (count_o),
        .empty_cycles_o(empty_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // One clock; afterwards the responder answers requests with data = addr + 0x100.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (auto_mem) begin
            imem_ack_i = 1'b0;
            if (imem_req_o) begin
                if (wait_cnt >= ack_delay) begin
                    checks++;
                    if (imem_addr_o !== exp_pc) begin
                        failures++;
                        $display("FAIL mem_addr got=%h exp=%h", imem_addr_o, exp_pc);
                    end
                    imem_ack_i  = 1'b1;
                    imem_data_i = exp_pc + 32'h100;
                    exp_q.push_back({exp_pc, exp_pc + 32'h100});
                    exp_pc   = exp_pc + 32'd4;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    endtask

    task automatic do_reset();
        auto_mem      = 1'b0;
        rst_i         = 1'b1;
        start_i       = 1'b0;
        imem_ack_i    = 1'b0;
        imem_data_i   = 32'h0;
        deq_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        wait_cnt      = 0;
        ack_delay     = 0;
        exp_pc        = 32'h0;
        exp_q.delete();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (count_o !== '0)            begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        if (valid_o !== 1'b0)          begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        if (imem_req_o !== 1'b0)       begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
        if (inst_o !== 32'h0)          begin failures++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
        if (pc_o !== 32'h0)            begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        if (empty_cycles_o !== 32'h0)  begin failures++; $display("FAIL reset_perf got=%h exp=0", empty_cycles_o); end
    endtask

    task automatic test_fill();
        do_reset();
        auto_mem  = 1'b1;
        ack_delay = 0;
        start_i   = 1'b1;
        repeat (8) tick();
        checks += 3;
        if (count_o !== CW'(DEPTH)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count_o, DEPTH); end
        if (pc_o !== 32'h0)         begin failures++; $display("FAIL fill_head_pc got=%h exp=0", pc_o); end
        if (inst_o !== 32'h100)     begin failures++; $display("FAIL fill_head_inst got=%h exp=100", inst_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (imem_req_o !== 1'b0) begin failures++; $display("FAIL full_no_req cycle=%0d got=%b exp=0", i, imem_req_o); end
        end
    endtask

    task automatic test_deq_one();
        checks++;
        if ({pc_o, inst_o} !== exp_q[0]) begin failures++; $display("FAIL deq_head got=%h exp=%h", {pc_o, inst_o}, exp_q[0]); end
        void'(exp_q.pop_front());
        deq_i = 1'b1;
        tick();
        deq_i = 1'b0;
        checks += 3;
        if (count_o !== CW'(3))          begin failures++; $display("FAIL deq_count got=%0d exp=3", count_o); end
        if (pc_o !== 32'h4)              begin failures++; $display("FAIL deq_pc got=%h exp=4", pc_o); end
        if ({pc_o, inst_o} !== exp_q[0]) begin failures++; $display("FAIL deq_next got=%h exp=%h", {pc_o, inst_o}, exp_q[0]); end
        tick();
        checks += 2;
        if (imem_req_o !== 1'b1)    begin failures++; $display("FAIL refill_req got=%b exp=1", imem_req_o); end
        if (imem_addr_o !== 32'h10) begin failures++; $display("FAIL refill_addr got=%h exp=10", imem_addr_o); end
        tick();
        checks++;
        if (count_o !== CW'(DEPTH)) begin failures++; $display("FAIL refill_count got=%0d exp=%0d", count_o, DEPTH); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            if (valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra cycle=%0d got=%h exp=none", i, {pc_o, inst_o});
                    deq_i = 1'b0;
                end else begin
                    if ({pc_o, inst_o} !== exp_q[0]) begin
                        failures++;
                        $display("FAIL b2b_head cycle=%0d got=%h exp=%h", i, {pc_o, inst_o}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    deq_i = 1'b1;
                end
            end else begin
                deq_i = 1'b0;
            end
            tick();
        end
        deq_i = 1'b0;
        checks++;
        if (int'(count_o) !== exp_q.size() - int'(imem_ack_i)) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", count_o, exp_q.size() - int'(imem_ack_i));
        end
        repeat (8) tick();
        checks++;
        if (count_o !== CW'(DEPTH)) begin failures++; $display("FAIL b2b_refill got=%0d exp=%0d", count_o, DEPTH); end
    endtask

    task automatic test_start_drop();
        bit seen;
        do_reset();
        auto_mem  = 1'b1;
        ack_delay = 2;
        start_i   = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick();
            seen = imem_req_o;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL start_req_timeout got=0 exp=1"); end
        start_i = 1'b0;
        repeat (6) tick();
        checks += 4;
        if (count_o !== CW'(1))  begin failures++; $display("FAIL stop_count got=%0d exp=1", count_o); end
        if (imem_req_o !== 1'b0) begin failures++; $display("FAIL stop_req got=%b exp=0", imem_req_o); end
        if (pc_o !== 32'h0)      begin failures++; $display("FAIL stop_pc got=%h exp=0", pc_o); end
        if (inst_o !== 32'h100)  begin failures++; $display("FAIL stop_inst got=%h exp=100", inst_o); end
        start_i = 1'b1;
        tick();
        checks += 2;
        if (imem_req_o !== 1'b1)   begin failures++; $display("FAIL restart_req got=%b exp=1", imem_req_o); end
        if (imem_addr_o !== 32'h4) begin failures++; $display("FAIL restart_addr got=%h exp=4", imem_addr_o); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        start_i = 1'b1;
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'h100;
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'h104;
        tick();
        imem_ack_i = 1'b0;
        checks += 2;
        if (imem_addr_o !== 32'h8) begin failures++; $display("FAIL rd_pre_addr got=%h exp=8", imem_addr_o); end
        if (count_o !== CW'(2))    begin failures++; $display("FAIL rd_pre_count got=%0d exp=2", count_o); end
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        checks += 3;
        if (count_o !== '0)      begin failures++; $display("FAIL rd_count got=%0d exp=0", count_o); end
        if (valid_o !== 1'b0)    begin failures++; $display("FAIL rd_valid got=%b exp=0", valid_o); end
        if (imem_req_o !== 1'b1) begin failures++; $display("FAIL rd_drop_req got=%b exp=1", imem_req_o); end
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'hDEADBEEF;
        tick();
        imem_ack_i = 1'b0;
        checks++;
        if (count_o !== '0) begin failures++; $display("FAIL rd_stale_write got=%0d exp=0", count_o); end
        tick();
        checks += 2;
        if (imem_req_o !== 1'b1)    begin failures++; $display("FAIL rd_new_req got=%b exp=1", imem_req_o); end
        if (imem_addr_o !== 32'h40) begin failures++; $display("FAIL rd_new_addr got=%h exp=40", imem_addr_o); end
        imem_ack_i = 1'b1; imem_data_i = 32'h140;
        tick();
        imem_ack_i = 1'b0;
        checks += 3;
        if (valid_o !== 1'b1)   begin failures++; $display("FAIL rd_first_valid got=%b exp=1", valid_o); end
        if (pc_o !== 32'h40)    begin failures++; $display("FAIL rd_first_pc got=%h exp=40", pc_o); end
        if (inst_o !== 32'h140) begin failures++; $display("FAIL rd_first_inst got=%h exp=140", inst_o); end
    endtask

    task automatic test_redirect_ack_deq();
        do_reset();
        start_i = 1'b1;
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'h100;
        tick();
        imem_ack_i = 1'b1; imem_data_i = 32'h104;
        tick();
        imem_ack_i = 1'b0;
        checks++;
        if (count_o !== CW'(2)) begin failures++; $display("FAIL rad_pre_count got=%0d exp=2", count_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h80;
        imem_ack_i = 1'b1; imem_data_i = 32'h5555;
        deq_i      = 1'b1;
        tick();
        redirect_i = 1'b0; imem_ack_i = 1'b0; deq_i = 1'b0;
        checks += 3;
        if (count_o !== '0)      begin failures++; $display("FAIL rad_count got=%0d exp=0", count_o); end
        if (valid_o !== 1'b0)    begin failures++; $display("FAIL rad_valid got=%b exp=0", valid_o); end
        if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rad_idle got=%b exp=0", imem_req_o); end
        tick();
        checks++;
        if (imem_addr_o !== 32'h80 || imem_req_o !== 1'b1) begin
            failures++; $display("FAIL rad_next got=%b/%h exp=1/80", imem_req_o, imem_addr_o);
        end
        imem_ack_i = 1'b1; imem_data_i = 32'h180;
        tick();
        imem_ack_i = 1'b0;
        checks += 2;
        if (count_o !== CW'(1)) begin failures++; $display("FAIL rad_fill_count got=%0d exp=1", count_o); end
        if (pc_o !== 32'h80)    begin failures++; $display("FAIL rad_fill_pc got=%h exp=80", pc_o); end

        // Asynchronous reset while the request at 0x84 is outstanding, then a stale ack.
        #2;
        rst_i = 1'b1;
        #1;
        checks += 3;
        if (imem_req_o !== 1'b0) begin failures++; $display("FAIL async_req got=%b exp=0", imem_req_o); end
        if (count_o !== '0)      begin failures++; $display("FAIL async_count got=%0d exp=0", count_o); end
        if (pc_o !== 32'h0)      begin failures++; $display("FAIL async_pc got=%h exp=0", pc_o); end
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        imem_ack_i = 1'b1; imem_data_i = 32'h9999;
        tick();
        imem_ack_i = 1'b0;
        checks += 2;
        if (count_o !== '0)      begin failures++; $display("FAIL stale_count got=%0d exp=0", count_o); end
        if (imem_req_o !== 1'b0) begin failures++; $display("FAIL stale_req got=%b exp=0", imem_req_o); end
    endtask

    task automatic test_perf();
        do_reset();
        start_i = 1'b1;
        repeat (5) tick();
        checks++;
        if (empty_cycles_o !== PERF_EXP) begin failures++; $display("FAIL perf_5 got=%0d exp=%0d", empty_cycles_o, PERF_EXP); end
        start_i = 1'b0;
        repeat (2) tick();
        checks++;
        if (empty_cycles_o !== PERF_EXP) begin failures++; $display("FAIL perf_hold got=%0d exp=%0d", empty_cycles_o, PERF_EXP); end
        imem_ack_i = 1'b1; imem_data_i = 32'h100;
        tick();
        imem_ack_i = 1'b0;
        start_i    = 1'b1;
        tick();
        checks += 2;
        if (valid_o !== 1'b1)            begin failures++; $display("FAIL perf_valid got=%b exp=1", valid_o); end
        if (empty_cycles_o !== PERF_EXP) begin failures++; $display("FAIL perf_nonempty got=%0d exp=%0d", empty_cycles_o, PERF_EXP); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_deq_one();
        test_back_to_back();
        test_start_drop();
        test_redirect_drop();
        test_redirect_ack_deq();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
